// File: rtl/turbo_enc_rsc_param.sv
// Rate-1/3 turbo encoder: two 8-state RSC encoders, the second fed through pi(i) = (P*i) mod K.
// Latency: first word is valid the cycle after bit K-1 is accepted; a block is K+3 output words.
// Backpressure: out_ready low freezes state and out_word; in_ready is low while encoding/terminating.
module turbo_enc_rsc_param #(
    parameter int K = 40,
    parameter int P = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_word,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam int AW = $clog2(K);

    function automatic int gcd_f(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        for (int n = 0; n < 64; n++) begin
            if (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    // Illegal geometries must stop elaboration rather than produce a broken interleaver.
    if (K < 8 || K > 1024) begin : g_bad_k
        $error("turbo_enc_rsc_param: K=%0d outside 8..1024", K);
    end
    if (gcd_f(K, P) != 1) begin : g_bad_p
        $error("turbo_enc_rsc_param: P=%0d is not coprime to K=%0d", P, K);
    end

    // Step reduced mod K so that j+P always stays below 2K.
    localparam logic [AW:0]   STEP_W = (AW+1)'(P % K);
    localparam logic [AW:0]   K_W    = (AW+1)'(K);
    localparam logic [AW-1:0] KM1    = AW'(K - 1);
    localparam logic [AW-1:0] TAIL_LAST = AW'(2);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ENC  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] j_q, j_d;
    logic [K-1:0]  mem_q, mem_d;
    // RSC state vectors: [0]=D1, [1]=D2, [2]=D3
    logic [2:0]    s1_q, s1_d;
    logic [2:0]    s2_q, s2_d;

    logic          u1, u2, a1, a2, z1, z2;
    logic [AW:0]   j_sum;

    // Next-state, encoder arithmetic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        j_d       = j_q;
        mem_d     = mem_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_word  = 4'b0000;
        out_last  = 1'b0;
        busy      = 1'b0;
        u1        = 1'b0;
        u2        = 1'b0;
        a1        = 1'b0;
        a2        = 1'b0;
        z1        = 1'b0;
        z2        = 1'b0;
        j_sum     = {1'b0, j_q} + STEP_W;

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_d[cnt_q] = in_bit;
                    if (cnt_q == KM1) begin
                        state_d = ST_ENC;
                        cnt_d   = '0;
                        j_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_ENC: begin
                u1        = mem_q[cnt_q];
                u2        = mem_q[j_q];
                a1        = u1 ^ s1_q[1] ^ s1_q[2];
                a2        = u2 ^ s2_q[1] ^ s2_q[2];
                z1        = a1 ^ s1_q[0] ^ s1_q[2];
                z2        = a2 ^ s2_q[0] ^ s2_q[2];
                out_valid = 1'b1;
                busy      = 1'b1;
                out_word  = {u1, z1, z2, 1'b0};
                if (out_ready) begin
                    s1_d = {s1_q[1:0], a1};
                    s2_d = {s2_q[1:0], a2};
                    j_d  = (j_sum >= K_W) ? AW'(j_sum - K_W) : AW'(j_sum);
                    if (cnt_q == KM1) begin
                        state_d = ST_TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_TAIL: begin
                // Input chosen to cancel the feedback, flushing a zero into D1.
                u1        = s1_q[1] ^ s1_q[2];
                u2        = s2_q[1] ^ s2_q[2];
                z1        = s1_q[0] ^ s1_q[2];
                z2        = s2_q[0] ^ s2_q[2];
                out_valid = 1'b1;
                busy      = 1'b1;
                out_word  = {u1, z1, z2, u2};
                out_last  = (cnt_q == TAIL_LAST);
                if (out_ready) begin
                    s1_d = {s1_q[1:0], 1'b0};
                    s2_d = {s2_q[1:0], 1'b0};
                    if (cnt_q == TAIL_LAST) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase

        // Nothing is offered or accepted while reset is asserted.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_word  = 4'b0000;
            out_last  = 1'b0;
            busy      = 1'b0;
        end
    end

    // State register; reset drops any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            j_q     <= '0;
            mem_q   <= '0;
            s1_q    <= 3'b000;
            s2_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            mem_q   <= mem_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

endmodule

// File: tb/tb_turbo_enc_rsc_param.sv
module tb_turbo_enc_rsc_param;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       in_bit    [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] out_word  [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       out_last  [2];
    logic       busy      [2];

    turbo_enc_rsc_param #(.K(8), .P(3)) dut8 (
        .clk(clk), .rst(rst[0]), .in_bit(in_bit[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_word(out_word[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0]), .busy(busy[0])
    );

    turbo_enc_rsc_param #(.K(40), .P(13)) dut40 (
        .clk(clk), .rst(rst[1]), .in_bit(in_bit[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_word(out_word[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];

    bit         rnd_rdy  [2] = '{0, 0};
    int         popped   [2] = '{0, 0};
    int         lasts    [2] = '{0, 0};
    bit         chk_rdy  [2] = '{0, 0};
    bit         stalled  [2] = '{0, 0};
    logic [3:0] held     [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [4:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int d, input logic [4:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Reference: feedback sequence a[n] = u[n]^a[n-2]^a[n-3], parity z[n] = a[n]^a[n-1]^a[n-3].
    task automatic model(input int d, input int kk, input int pp, input bitq_t bits);
        bit a1[$];
        bit a2[$];
        bit u1, u2, f1, f2, z1, z2, tail;
        int n;
        a1 = '{0, 0, 0};
        a2 = '{0, 0, 0};
        for (int t = 0; t < kk + 3; t++) begin
            n    = t + 3;
            tail = (t >= kk);
            if (!tail) begin
                u1 = bits[t];
                u2 = bits[(pp * t) % kk];
                f1 = u1 ^ a1[n-2] ^ a1[n-3];
                f2 = u2 ^ a2[n-2] ^ a2[n-3];
            end else begin
                u1 = a1[n-2] ^ a1[n-3];
                u2 = a2[n-2] ^ a2[n-3];
                f1 = 1'b0;
                f2 = 1'b0;
            end
            z1 = f1 ^ a1[n-1] ^ a1[n-3];
            z2 = f2 ^ a2[n-1] ^ a2[n-3];
            a1.push_back(f1);
            a2.push_back(f2);
            qpush(d, {(t == kk + 2), u1, z1, z2, (tail ? u2 : 1'b0)});
        end
    endtask

    function automatic bitq_t rand_block(input int kk);
        bitq_t b;
        for (int i = 0; i < kk; i++) b.push_back(1'($urandom % 2));
        return b;
    endfunction

    // Feed one block; optionally random in_valid gaps and junk driven while the DUT is busy.
    task automatic send_block(input int d, input bitq_t bits, input bit gaps, input bit junk);
        bit acc;
        int n;
        for (int i = 0; i < bits.size(); i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                in_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            in_valid[d] = 1'b1;
            in_bit[d]   = bits[i];
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 1000) begin
                @(negedge clk);
                acc = in_ready[d];
                @(posedge clk); #1;
                n++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL send_timeout: dut %0d bit %0d not accepted", d, i);
                in_valid[d] = 1'b0;
                return;
            end
        end
        in_valid[d] = 1'b0;
        if (junk) begin
            for (int c = 0; c < 4; c++) begin
                in_valid[d] = 1'b1;
                in_bit[d]   = 1'($urandom % 2);
                @(posedge clk); #1;
            end
            in_valid[d] = 1'b0;
        end
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || out_valid[d] !== 1'b0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", qsize(d), 0);
    endtask

    // out_ready: either always high or a fair coin per cycle.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) out_ready[d] = rnd_rdy[d] ? 1'($urandom % 2) : 1'b1;
    end

    // Monitor: compares every presented word against the scoreboard head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d] === 1'b1) begin
                stalled[d] = 1'b0;
                chk_rdy[d] = 1'b0;
            end else begin
                if (chk_rdy[d]) begin
                    chk("in_ready_after_last", in_ready[d], 1);
                    chk("busy_after_last", busy[d], 0);
                    chk_rdy[d] = 1'b0;
                end
                if (stalled[d]) begin
                    chk("stall_valid_held", out_valid[d], 1);
                    chk("stall_word_held", out_word[d], held[d]);
                end
                stalled[d] = 1'b0;
                if (out_valid[d] === 1'b1) begin
                    if (qsize(d) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: dut %0d got %b with nothing expected", d, out_word[d]);
                    end else begin
                        chk($sformatf("word_dut%0d_n%0d", d, popped[d]),
                            {out_last[d], out_word[d]}, qfront(d));
                        if (out_ready[d] === 1'b1) begin
                            qpop(d);
                            popped[d]++;
                            if (out_last[d] === 1'b1) begin
                                lasts[d]++;
                                chk_rdy[d] = 1'b1;
                            end
                        end else begin
                            stalled[d] = 1'b1;
                            held[d]    = out_word[d];
                        end
                    end
                end
            end
        end
    end

    initial begin
        bitq_t b;
        bitq_t b2;
        int    base;
        int    lbase;
        int    n;

        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            in_valid[d] = 1'b0;
            in_bit[d]   = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", in_ready[d], 0);
            chk("reset_out_valid", out_valid[d], 0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("idle_in_ready", in_ready[d], 1);
            chk("idle_out_valid", out_valid[d], 0);
            chk("idle_out_word", out_word[d], 0);
            chk("idle_out_last", out_last[d], 0);
            chk("idle_busy", busy[d], 0);
        end
        @(posedge clk); #1;

        // K=8: all-zero block
        b = '{0, 0, 0, 0, 0, 0, 0, 0};
        model(0, 8, 3, b);
        send_block(0, b, 1'b0, 1'b0);
        chk("busy_in_enc", busy[0], 1);
        wait_drain(0);

        // K=8: impulse at index 0, hand-derived words
        b = '{1, 0, 0, 0, 0, 0, 0, 0};
        qpush(0, 5'b01110); qpush(0, 5'b00110); qpush(0, 5'b00110); qpush(0, 5'b00110);
        qpush(0, 5'b00000); qpush(0, 5'b00000); qpush(0, 5'b00110); qpush(0, 5'b00000);
        qpush(0, 5'b00110); qpush(0, 5'b01001); qpush(0, 5'b11111);
        send_block(0, b, 1'b0, 1'b0);
        wait_drain(0);

        // K=8: impulse at index 3, then a zero block proves the tail left a zero state
        b = '{0, 0, 0, 1, 0, 0, 0, 0};
        model(0, 8, 3, b);
        send_block(0, b, 1'b0, 1'b0);
        b = '{0, 0, 0, 0, 0, 0, 0, 0};
        model(0, 8, 3, b);
        send_block(0, b, 1'b0, 1'b0);
        wait_drain(0);

        // K=40: random blocks under random backpressure and input gaps
        rnd_rdy[1] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            b = rand_block(40);
            model(1, 40, 13, b);
            send_block(1, b, 1'b1, 1'b1);
        end
        wait_drain(1);

        // Abort mid-ENC while word 5 is presented
        rnd_rdy[1] = 1'b0;
        base = popped[1];
        b = rand_block(40);
        model(1, 40, 13, b);
        send_block(1, b, 1'b0, 1'b0);
        n = 0;
        while (popped[1] < base + 5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_word5", popped[1] - base, 5);
        rst[1] = 1'b1;
        q1.delete();
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid[1], 0);
        chk("abort_in_ready", in_ready[1], 1);
        chk("abort_busy", busy[1], 0);
        @(posedge clk); #1;

        // Two back-to-back blocks after the abort
        base  = popped[1];
        lbase = lasts[1];
        b  = rand_block(40);
        b2 = rand_block(40);
        model(1, 40, 13, b);
        model(1, 40, 13, b2);
        send_block(1, b, 1'b0, 1'b0);
        send_block(1, b2, 1'b0, 1'b0);
        wait_drain(1);
        chk("b2b_word_count", popped[1] - base, 86);
        chk("b2b_last_count", lasts[1] - lbase, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
